biriscv_icache_flush_ctrl: RTL and testbench

Sequences a full instruction-cache invalidation for fence.i (from exec) and for debug-initiated flushes (from JTAG). It holds the fetch stage and waits for any outstanding icache fetch to drain. It then walks every line index, issuing one invalidate per line with a valid/accept handshake. Finally it issues a single-cycle redirect to the refetch PC. It sits between exec/debug and the fetch/icache pair and drives the fetch hold and branch-redirect inputs.

---
 rtl/biriscv_flush_pkg.sv | 15 +
 rtl/biriscv_icache_flush_ctrl.sv | 142 ++++++++++++++
 tb/tb_biriscv_icache_flush_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biriscv_flush_pkg.sv
// Shared definitions for the icache flush controller: FSM state encoding and
// the widths of the optional statistics counters (ICACHE_FLUSH_STATS_EN).
package biriscv_flush_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StWalk  = 2'd2,
    StDone  = 2'd3
  } flush_state_e;

  localparam int unsigned FlushCountW  = 16;
  localparam int unsigned FlushCyclesW = 32;

endpackage

// File: rtl/biriscv_icache_flush_ctrl.sv
// Full icache invalidation sequencer for fence.i and debug flushes: hold fetch, drain,
// walk every line index, then redirect. ICACHE_FLUSH_STATS_EN adds flush statistics.
module biriscv_icache_flush_ctrl
  import biriscv_flush_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 256,
  parameter int unsigned LINE_IDX_W = $clog2(NUM_LINES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_req_i,
  input  logic [31:0]             flush_pc_i,
  input  logic                    dbg_flush_req_i,
  input  logic                    fetch_idle_i,
  output logic                    inv_valid_o,
  output logic [LINE_IDX_W-1:0]   inv_idx_o,
  input  logic                    inv_accept_i,
  output logic                    fetch_hold_o,
  output logic                    redirect_o,
  output logic [31:0]             redirect_pc_o,
  output logic                    flush_busy_o,
  output logic                    flush_done_o
`ifdef ICACHE_FLUSH_STATS_EN
  ,
  output logic [FlushCountW-1:0]  flush_count_o,
  output logic [FlushCyclesW-1:0] flush_cycles_o
`endif
);

  flush_state_e          state_q, state_d;
  logic [LINE_IDX_W-1:0] idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  pend_redir_q, pend_redir_d;
  logic                  redir_q, redir_d;
  logic [31:0]           pc_q, pc_d;
  logic                  any_req;
  logic                  last_idx;

  assign any_req  = flush_req_i | dbg_flush_req_i;
  assign last_idx = (idx_q == LINE_IDX_W'(NUM_LINES - 1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    pend_redir_d = pend_redir_q;
    redir_d      = redir_q;
    pc_d         = pc_q;

    // The most recent fence.i PC always wins, whichever flush ends up using it.
    if (flush_req_i) begin
      pc_d = flush_pc_i;
    end

    if ((state_q == StDrain) || (state_q == StWalk)) begin
      if (any_req) begin
        pending_d = 1'b1;
      end
      if (flush_req_i) begin
        redir_d      = 1'b1;
        pend_redir_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StDrain;
          redir_d = flush_req_i;
        end
      end
      StDrain: begin
        if (fetch_idle_i) begin
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (inv_accept_i) begin
          idx_d = idx_q + LINE_IDX_W'(1);
          if (last_idx) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        pending_d    = 1'b0;
        pend_redir_d = 1'b0;
        // A request landing in this cycle is folded straight into the follow-on flush.
        if (pending_q || any_req) begin
          state_d = StDrain;
          redir_d = pend_redir_q | flush_req_i;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      pend_redir_q <= 1'b0;
      redir_q      <= 1'b0;
      pc_q         <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_redir_q <= pend_redir_d;
      redir_q      <= redir_d;
      pc_q         <= pc_d;
    end
  end

  assign flush_busy_o  = (state_q != StIdle);
  assign fetch_hold_o  = (state_q == StDrain) || (state_q == StWalk);
  assign inv_valid_o   = (state_q == StWalk);
  assign inv_idx_o     = idx_q;
  assign flush_done_o  = (state_q == StDone);
  assign redirect_o    = flush_done_o & redir_q;
  assign redirect_pc_o = redirect_o ? pc_q : 32'h0;

`ifdef ICACHE_FLUSH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_count_o  <= '0;
      flush_cycles_o <= '0;
    end else begin
      if (flush_done_o && (flush_count_o != '1)) begin
        flush_count_o <= flush_count_o + FlushCountW'(1);
      end
      if (flush_busy_o) begin
        flush_cycles_o <= flush_cycles_o + FlushCyclesW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_biriscv_icache_flush_ctrl.sv
// Self-checking bench for biriscv_icache_flush_ctrl (NUM_LINES=4): directed scenarios plus
// randomized traffic against a behavioural model; stats checked when ICACHE_FLUSH_STATS_EN.
module tb_biriscv_icache_flush_ctrl;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic        dbg_flush_req_i;
  logic        fetch_idle_i;
  logic        inv_valid_o;
  logic [1:0]  inv_idx_o;
  logic        inv_accept_i;
  logic        fetch_hold_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_busy_o;
  logic        flush_done_o;
`ifdef ICACHE_FLUSH_STATS_EN
  logic [15:0] flush_count_o;
  logic [31:0] flush_cycles_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  biriscv_icache_flush_ctrl #(
    .NUM_LINES (N)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_req_i     (flush_req_i),
    .flush_pc_i      (flush_pc_i),
    .dbg_flush_req_i (dbg_flush_req_i),
    .fetch_idle_i    (fetch_idle_i),
    .inv_valid_o     (inv_valid_o),
    .inv_idx_o       (inv_idx_o),
    .inv_accept_i    (inv_accept_i),
    .fetch_hold_o    (fetch_hold_o),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o),
    .flush_busy_o    (flush_busy_o),
    .flush_done_o    (flush_done_o)
`ifdef ICACHE_FLUSH_STATS_EN
    ,
    .flush_count_o   (flush_count_o),
    .flush_cycles_o  (flush_cycles_o)
`endif
  );

  function automatic logic [38:0] outs();
    return {inv_valid_o, inv_idx_o, fetch_hold_o, redirect_o, redirect_pc_o,
            flush_busy_o, flush_done_o};
  endfunction

  task automatic test_reset;
    rst = 1'b1; flush_req_i = 1'b0; flush_pc_i = '0; dbg_flush_req_i = 1'b0;
    fetch_idle_i = 1'b1; inv_accept_i = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (outs() !== 39'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", outs());
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (outs() !== 39'h0) begin
      bad++; $display("FAIL post_reset_idle: got %h want 0", outs());
    end
  endtask

  task automatic test_basic;
    int busy_cnt;
    busy_cnt = 0;
    fetch_idle_i = 1'b1; inv_accept_i = 1'b1;
    flush_req_i = 1'b1; flush_pc_i = 32'h8000_0100;
    @(negedge clk);
    flush_req_i = 1'b0; flush_pc_i = 32'h0;
    busy_cnt += int'(flush_busy_o);
    total++;
    if ({fetch_hold_o, inv_valid_o, flush_busy_o, flush_done_o} !== 4'b1010) begin
      bad++; $display("FAIL basic_drain: hold/valid/busy/done=%b want 1010",
                      {fetch_hold_o, inv_valid_o, flush_busy_o, flush_done_o});
    end
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      busy_cnt += int'(flush_busy_o);
      total++;
      if ({inv_valid_o, fetch_hold_o} !== 2'b11 || int'(inv_idx_o) != i) begin
        bad++; $display("FAIL basic_walk: valid=%b hold=%b idx=%0d want 1 1 %0d",
                        inv_valid_o, fetch_hold_o, inv_idx_o, i);
      end
    end
    @(negedge clk);
    busy_cnt += int'(flush_busy_o);
    total++;
    if ({flush_done_o, redirect_o, fetch_hold_o, inv_valid_o} !== 4'b1100 ||
        redirect_pc_o !== 32'h8000_0100) begin
      bad++; $display("FAIL basic_done: done/redir/hold/valid=%b pc=%h want 1100 80000100",
                      {flush_done_o, redirect_o, fetch_hold_o, inv_valid_o}, redirect_pc_o);
    end
    @(negedge clk);
    busy_cnt += int'(flush_busy_o);
    total++;
    if (outs() !== 39'h0 || busy_cnt != 6) begin
      bad++; $display("FAIL basic_busy_cycles: outs=%h busy=%0d want 0 and 6", outs(), busy_cnt);
    end
  endtask

  task automatic test_drain_stall;
    bit done_seen;
    done_seen = 1'b0;
    fetch_idle_i = 1'b0; inv_accept_i = 1'b1;
    flush_req_i = 1'b1; flush_pc_i = 32'h0000_0400;
    @(negedge clk);
    flush_req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({fetch_hold_o, inv_valid_o} !== 2'b10) begin
        bad++; $display("FAIL drain_stall cycle %0d: hold/valid=%b want 10", i,
                        {fetch_hold_o, inv_valid_o});
      end
      if (i == 4) fetch_idle_i = 1'b1;
      @(negedge clk);
    end
    total++;
    if (inv_valid_o !== 1'b1 || inv_idx_o !== 2'd0) begin
      bad++; $display("FAIL drain_release: valid=%b idx=%0d want 1 0", inv_valid_o, inv_idx_o);
    end
    for (int i = 0; i < 20 && !done_seen; i++) begin
      if (flush_done_o) done_seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!done_seen || redirect_pc_o !== 32'h0000_0400) begin
      bad++; $display("FAIL drain_done: seen=%b pc=%h want 1 00000400", done_seen, redirect_pc_o);
    end
    @(negedge clk);
  endtask

  task automatic test_accept_toggle;
    int  accepts;
    int  exp_idx;
    bit  done_seen;
    logic [1:0] want;
    accepts = 0; exp_idx = 0; done_seen = 1'b0;
    fetch_idle_i = 1'b1; inv_accept_i = 1'b0;
    flush_req_i = 1'b1; flush_pc_i = 32'h0000_1234;
    @(negedge clk);
    flush_req_i = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 64 && !done_seen; c++) begin
      if (flush_done_o) begin
        done_seen = 1'b1;
      end else begin
        want = exp_idx[1:0];
        total++;
        if (inv_valid_o !== 1'b1 || inv_idx_o !== want || exp_idx >= int'(N)) begin
          bad++; $display("FAIL accept_toggle_idx: valid=%b idx=%0d want 1 %0d",
                          inv_valid_o, inv_idx_o, exp_idx);
        end
        inv_accept_i = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        if (inv_accept_i) begin
          accepts++; exp_idx++;
        end
        @(negedge clk);
      end
    end
    inv_accept_i = 1'b1;
    total++;
    if (!done_seen || accepts != int'(N)) begin
      bad++; $display("FAIL accept_toggle_count: done=%b accepts=%0d want 1 %0d",
                      done_seen, accepts, N);
    end
    @(negedge clk);
  endtask

  task automatic test_dbg_pending;
    bit done_seen;
    fetch_idle_i = 1'b1; inv_accept_i = 1'b1;
    // Debug-only flush: no redirect.
    dbg_flush_req_i = 1'b1;
    @(negedge clk);
    dbg_flush_req_i = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      if (flush_done_o) done_seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!done_seen || redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
      bad++; $display("FAIL dbg_only_done: done=%b redir=%b pc=%h want 1 0 0",
                      done_seen, redirect_o, redirect_pc_o);
    end
    @(negedge clk);
    // Debug flush, then fence.i mid-WALK: PC applies now and to the queued flush.
    dbg_flush_req_i = 1'b1;
    @(negedge clk);
    dbg_flush_req_i = 1'b0;
    repeat (2) @(negedge clk);
    flush_req_i = 1'b1; flush_pc_i = 32'h0000_0200;
    @(negedge clk);
    flush_req_i = 1'b0; flush_pc_i = 32'h0;
    done_seen = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      if (flush_done_o) done_seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!done_seen || redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_0200) begin
      bad++; $display("FAIL pending_first_done: done=%b redir=%b pc=%h want 1 1 00000200",
                      done_seen, redirect_o, redirect_pc_o);
    end
    @(negedge clk);
    total++;
    if ({flush_busy_o, fetch_hold_o, inv_valid_o, flush_done_o} !== 4'b1100) begin
      bad++; $display("FAIL pending_back_to_back: busy/hold/valid/done=%b want 1100",
                      {flush_busy_o, fetch_hold_o, inv_valid_o, flush_done_o});
    end
    done_seen = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      if (flush_done_o) done_seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!done_seen || redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_0200) begin
      bad++; $display("FAIL pending_second_done: done=%b redir=%b pc=%h want 1 1 00000200",
                      done_seen, redirect_o, redirect_pc_o);
    end
    @(negedge clk);
    total++;
    if (outs() !== 39'h0) begin
      bad++; $display("FAIL pending_drained: outs=%h want 0", outs());
    end
  endtask

  task automatic test_reset_mid;
    bit done_seen;
    fetch_idle_i = 1'b1; inv_accept_i = 1'b1;
    flush_req_i = 1'b1; flush_pc_i = 32'h0000_0040;
    @(negedge clk);
    flush_req_i = 1'b0;
    @(negedge clk);
    dbg_flush_req_i = 1'b1;
    @(negedge clk);
    dbg_flush_req_i = 1'b0;
    @(negedge clk);
    total++;
    if (inv_valid_o !== 1'b1 || inv_idx_o !== 2'd2) begin
      bad++; $display("FAIL reset_mid_setup: valid=%b idx=%0d want 1 2", inv_valid_o, inv_idx_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (outs() !== 39'h0) begin
      bad++; $display("FAIL reset_mid_outputs: outs=%h want 0", outs());
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (outs() !== 39'h0) begin
        bad++; $display("FAIL reset_mid_pending_dropped: outs=%h want 0", outs());
      end
    end
    dbg_flush_req_i = 1'b1;
    @(negedge clk);
    dbg_flush_req_i = 1'b0;
    @(negedge clk);
    total++;
    if (inv_valid_o !== 1'b1 || inv_idx_o !== 2'd0) begin
      bad++; $display("FAIL reset_mid_restart_idx: valid=%b idx=%0d want 1 0",
                      inv_valid_o, inv_idx_o);
    end
    done_seen = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      if (flush_done_o) done_seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!done_seen) begin
      bad++; $display("FAIL reset_mid_restart_done: timeout waiting for done");
    end
    @(negedge clk);
  endtask

`ifdef ICACHE_FLUSH_STATS_EN
  task automatic test_stats;
    bit done_seen;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fetch_idle_i = 1'b1; inv_accept_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      flush_req_i = 1'b1; flush_pc_i = 32'h100 * (f + 1);
      @(negedge clk);
      flush_req_i = 1'b0;
      done_seen = 1'b0;
      for (int i = 0; i < 20 && !done_seen; i++) begin
        if (flush_done_o) done_seen = 1'b1;
        else @(negedge clk);
      end
      @(negedge clk);
    end
    total++;
    if (flush_count_o !== 16'd3 || flush_cycles_o !== 32'd18) begin
      bad++; $display("FAIL stats: count=%0d cycles=%0d want 3 18", flush_count_o, flush_cycles_o);
    end
  endtask
`endif

  // Model tracks the flush job in terms of its phase, lines invalidated so far and
  // whatever requests have been queued behind it.
  task automatic test_random;
    int          phase;      // 0 none, 1 waiting for fetch, 2 invalidating, 3 completing
    int          lines_done;
    bit          queued, queued_pc, want_redir, again;
    logic [31:0] tgt_pc;
    bit          exp_redir;
    logic [38:0] exp_o;
    rst = 1'b1; flush_req_i = 1'b0; dbg_flush_req_i = 1'b0;
    @(posedge clk);
    phase = 0; lines_done = 0; queued = 0; queued_pc = 0; want_redir = 0; tgt_pc = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      exp_redir = (phase == 3) && want_redir;
      exp_o = {phase == 2, 2'(lines_done), (phase == 1) || (phase == 2), exp_redir,
               exp_redir ? tgt_pc : 32'h0, phase != 0, phase == 3};
      total++;
      if (outs() !== exp_o) begin
        bad++; $display("FAIL random cycle %0d: outs=%h want %h", c, outs(), exp_o);
      end
      rst             = ($urandom_range(0, 199) == 0);
      flush_req_i     = ($urandom_range(0, 15) == 0);
      dbg_flush_req_i = ($urandom_range(0, 19) == 0);
      flush_pc_i      = $urandom;
      fetch_idle_i    = ($urandom_range(0, 9) < 7);
      inv_accept_i    = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      if (rst) begin
        phase = 0; lines_done = 0; queued = 0; queued_pc = 0; want_redir = 0; tgt_pc = '0;
      end else begin
        if (flush_req_i) tgt_pc = flush_pc_i;
        if (phase == 0) begin
          if (flush_req_i || dbg_flush_req_i) begin
            phase = 1; want_redir = flush_req_i;
          end
        end else if (phase == 3) begin
          again = queued || flush_req_i || dbg_flush_req_i;
          if (again) want_redir = queued_pc || flush_req_i;
          queued = 0; queued_pc = 0;
          phase = again ? 1 : 0;
        end else begin
          if (flush_req_i || dbg_flush_req_i) queued = 1;
          if (flush_req_i) begin
            want_redir = 1; queued_pc = 1;
          end
          if (phase == 1 && fetch_idle_i) begin
            phase = 2;
          end else if (phase == 2 && inv_accept_i) begin
            lines_done = (lines_done + 1) % int'(N);
            if (lines_done == 0) phase = 3;
          end
        end
      end
      @(negedge clk);
    end
    rst = 1'b0; flush_req_i = 1'b0; dbg_flush_req_i = 1'b0;
    fetch_idle_i = 1'b1; inv_accept_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain_stall();
    test_accept_toggle();
    test_dbg_pending();
    test_reset_mid();
`ifdef ICACHE_FLUSH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
